// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared FSM encoding and default sizing for the multiplier arbiter
package mult_arb_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int N_DEF       = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick starting one past the previous winner
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int            idx;
    logic [IW-1:0] idx_v;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_v = idx[IW-1:0];
            if (!found && req[idx_v]) begin
                found        = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one external serial multiplier among N requesters
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int Width   = WIDTH_DEF,
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*Width-1:0]   opa,
    input  logic [N*Width-1:0]   opb,
    output logic [N-1:0]         ack,
    output logic [2*Width-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 mult_en,
    output logic [Width-1:0]     mult_a,
    output logic [Width-1:0]     mult_b,
    input  logic [2*Width-1:0]   mult_product,
    input  logic                 mult_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [Width-1:0]     mult_a_q, mult_a_d;
    logic [Width-1:0]     mult_b_q, mult_b_d;
    logic [2*Width-1:0]   result_q, result_d;
    logic                 err_q, err_d;
    logic                 done_q;

    logic [N-1:0]         pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 done_rise;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_oh),
        .grant_idx  (pick_idx)
    );

    // A done level left high by the previous job must not complete this one
    assign done_rise = mult_done & ~done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q      <= '0;
            last_grant_q <= IW'(N - 1);
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            done_q       <= mult_done;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        result_d     = result_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (|pick_oh) begin
                    grant_d  = pick_idx;
                    mult_a_d = opa[pick_idx*Width +: Width];
                    mult_b_d = opb[pick_idx*Width +: Width];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    result_d     = mult_product;
                    err_d        = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d     = '0;
                    err_d        = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack     = '0;
        result  = '0;
        err     = 1'b0;
        busy    = (state_q != IDLE);
        mult_en = (state_q == ISSUE);
        mult_a  = mult_a_q;
        mult_b  = mult_b_q;
        if (state_q == RESP) begin
            ack[grant_q] = 1'b1;
            result       = result_q;
            err          = err_q;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench with requester, multiplier and arbitration models
module tb_mult_arbiter;

    localparam int W = 4;
    localparam int N = 4;
    localparam int T = 64;
    localparam int P = 2 * W;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] opa = '0;
    logic [N*W-1:0] opb = '0;
    logic [N-1:0]   ack;
    logic [P-1:0]   result;
    logic           err;
    logic           busy;
    logic           mult_en;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic [P-1:0]   mult_product = '0;
    logic           mult_done = 1'b0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .Width   (W),
        .N       (N),
        .TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .opa          (opa),
        .opb          (opb),
        .ack          (ack),
        .result       (result),
        .err          (err),
        .busy         (busy),
        .mult_en      (mult_en),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_product (mult_product),
        .mult_done    (mult_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Requester job queues and per-requester "request outstanding" flags
    int  qa [N][$];
    int  qb [N][$];
    bit  active [N];
    bit  hold_mode  = 1'b0;
    bit  never_done = 1'b0;
    bit  drop_en    = 1'b0;

    logic [N-1:0]   req_s = '0;
    logic [N*W-1:0] opa_s = '0;
    logic [N*W-1:0] opb_s = '0;

    int  cyc = 0, en_cyc = 0, exp_idx = 0, last_ref = N - 1;
    int  m_lat = 0, m_cnt = 0, en_count = 0, ack_count = 0;
    bit  inflight = 1'b0, m_busy = 1'b0;
    logic [P-1:0] exp_a = '0, exp_b = '0, m_prod = '0, last_res = '0;
    logic         last_err = 1'b0;
    int           ack_log[$];
    logic [P-1:0] res_log[$];

    function automatic int rr_ref(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        req_s = req;
        opa_s = opa;
        opb_s = opb;
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("reset_outputs", 64'({ack, result, err, busy, mult_en, mult_a, mult_b}), 64'd0);
            inflight  = 1'b0;
            last_ref  = N - 1;
            m_busy    = 1'b0;
            mult_done = 1'b0;
            req       = '0;
            for (int i = 0; i < N; i++) active[i] = 1'b0;
        end else begin
            if (mult_en) begin
                check("mult_en_single", 64'(inflight), 64'd0);
                exp_idx = rr_ref(req_s, last_ref);
                check("grant_has_req", 64'(exp_idx >= 0), 64'd1);
                if (exp_idx < 0) exp_idx = 0;
                exp_a = P'(opa_s[exp_idx*W +: W]);
                exp_b = P'(opb_s[exp_idx*W +: W]);
                check("mult_a", 64'(mult_a), 64'(exp_a));
                check("mult_b", 64'(mult_b), 64'(exp_b));
                inflight = 1'b1;
                en_cyc   = cyc;
                en_count++;
                m_busy = !never_done;
                m_lat  = hold_mode ? int'($urandom_range(5, 2)) : int'($urandom_range(5, 1));
                m_cnt  = m_lat;
                m_prod = exp_a * exp_b;
                if (!hold_mode) mult_done = 1'b0;
                if (drop_en && $urandom_range(1, 0) == 1) req[exp_idx] = 1'b0;
                opa[exp_idx*W +: W] = W'($urandom);
                opb[exp_idx*W +: W] = W'($urandom);
            end else if (never_done) begin
                mult_done = 1'b0;
            end else if (m_busy) begin
                if (m_cnt > 1) begin
                    if (hold_mode && m_cnt == 2) mult_done = 1'b0;
                    m_cnt--;
                end else begin
                    m_busy       = 1'b0;
                    mult_done    = 1'b1;
                    mult_product = m_prod;
                end
            end else if (!hold_mode) begin
                mult_done = 1'b0;
            end

            if (ack != '0) begin
                check("ack_in_flight", 64'(inflight), 64'd1);
                check("ack_onehot", 64'(ack), 64'(1) << exp_idx);
                check("result", 64'(result), never_done ? 64'd0 : 64'(exp_a * exp_b));
                check("err", 64'(err), 64'(never_done));
                check("latency", 64'(cyc - en_cyc), 64'(never_done ? T + 1 : m_lat + 1));
                ack_log.push_back(exp_idx);
                res_log.push_back(result);
                last_res = result;
                last_err = err;
                inflight = 1'b0;
                last_ref = exp_idx;
                active[exp_idx] = 1'b0;
                req[exp_idx]    = 1'b0;
                ack_count++;
            end

            for (int i = 0; i < N; i++) begin
                if (!active[i] && qa[i].size() > 0) begin
                    active[i]     = 1'b1;
                    req[i]        = 1'b1;
                    opa[i*W +: W] = W'(qa[i].pop_front());
                    opb[i*W +: W] = W'(qb[i].pop_front());
                end
            end
        end
    end

    function automatic bit all_done();
        bit d;
        d = !inflight && !busy;
        for (int i = 0; i < N; i++) begin
            if (active[i] || qa[i].size() != 0) d = 1'b0;
        end
        return d;
    endfunction

    task automatic post(input int i, input int a, input int b);
        qa[i].push_back(a);
        qb[i].push_back(b);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(posedge clk);
            #1;
            n++;
            ok = all_done();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        res_log.delete();
    endtask

    task automatic check_logs(input string tag, input int n, input int ords[4], input int ress[4]);
        check({tag, "_count"}, 64'(ack_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < ack_log.size()) begin
                check({tag, "_order"}, 64'(ack_log[i]), 64'(ords[i]));
                check({tag, "_result"}, 64'(res_log[i]), 64'(ress[i]));
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, a0, lim;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        e0 = en_count;
        a0 = ack_count;
        clear_logs();
        post(0, 3, 5);
        wait_idle("idle_single", 100);
        check("single_mult_en", 64'(en_count - e0), 64'd1);
        check("single_ack", 64'(ack_count - a0), 64'd1);
        check_logs("single", 1, '{0, 0, 0, 0}, '{15, 0, 0, 0});
        check("single_err", 64'(last_err), 64'd0);

        do_reset();
        clear_logs();
        post(0, 2, 3);
        post(1, 4, 5);
        post(2, 6, 7);
        post(3, 15, 15);
        wait_idle("idle_all4", 200);
        check_logs("all4", 4, '{0, 1, 2, 3}, '{6, 20, 42, 225});

        do_reset();
        clear_logs();
        post(0, 1, 2);
        post(0, 3, 4);
        post(2, 5, 6);
        post(2, 7, 8);
        wait_idle("idle_fair", 200);
        check_logs("fair", 4, '{0, 2, 0, 2}, '{2, 30, 12, 56});

        hold_mode = 1'b1;
        clear_logs();
        post(3, 0, 9);
        post(3, 7, 8);
        wait_idle("idle_hold", 200);
        check_logs("hold", 2, '{3, 3, 0, 0}, '{0, 56, 0, 0});
        hold_mode = 1'b0;

        never_done = 1'b1;
        clear_logs();
        post(2, 5, 6);
        wait_idle("idle_timeout", 300);
        check_logs("timeout", 1, '{2, 0, 0, 0}, '{0, 0, 0, 0});
        check("timeout_err", 64'(last_err), 64'd1);

        a0 = ack_count;
        post(1, 3, 4);
        lim = 0;
        while (!inflight && lim < 50) begin
            @(posedge clk);
            #1;
            lim++;
        end
        check("reset_job_started", 64'(inflight), 64'd1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_no_ack", 64'(ack_count - a0), 64'd0);
        reset      = 1'b1;
        never_done = 1'b0;
        clear_logs();
        post(1, 7, 8);
        wait_idle("idle_after_reset", 100);
        check_logs("after_reset", 1, '{1, 0, 0, 0}, '{56, 0, 0, 0});

        drop_en = 1'b1;
        for (int j = 0; j < 80; j++) begin
            post(int'($urandom_range(N - 1, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
            repeat ($urandom_range(6, 0)) @(posedge clk);
            #1;
        end
        wait_idle("idle_random", 5000);
        drop_en   = 1'b0;
        hold_mode = 1'b1;
        for (int j = 0; j < 60; j++) begin
            post(int'($urandom_range(N - 1, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
            repeat ($urandom_range(6, 0)) @(posedge clk);
            #1;
        end
        wait_idle("idle_random_hold", 5000);
        hold_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
